// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel types and opcodes shared by the mux and its device ports.
package tlul_pkg;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/student_fir_sample_fifo.sv
// TL-UL sample FIFO feeding the FIR core: software pushes via DATA, the core
// drains over valid/ready. Fill level and sticky overflow are visible in STATUS.
module student_fir_sample_fifo
  import tlul_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  tl_h2d_t       tl_i,
  output tl_d2h_t       tl_o,
  output logic [DW-1:0] sample_o,
  output logic          valid_o,
  input  logic          ready_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic                      rst_q;
  logic [DEPTH-1:0][DW-1:0]  mem_q;
  logic [PW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]             level_q, level_d;
  logic                      en_q, en_d, ovf_q, ovf_d;
  logic                      d_valid_q, d_error_q;
  logic [2:0]                d_opcode_q;
  logic [1:0]                d_size_q;
  logic [7:0]                d_source_q;
  logic [31:0]               d_data_q;

  logic        a_ready, accept, op_wr, op_rd, req_err;
  logic        push, push_ok, pop, ctrl_wr, flush, empty, full;
  logic [1:0]  reg_sel;
  logic [31:0] rdata;

  assign a_ready = rst_q && !d_valid_q;
  assign accept  = tl_i.a_valid && a_ready;
  assign reg_sel = tl_i.a_address[3:2];
  assign op_wr   = (tl_i.a_opcode == PutFullData) || (tl_i.a_opcode == PutPartialData);
  assign op_rd   = (tl_i.a_opcode == Get);
  assign req_err = !(op_wr || op_rd) || (reg_sel == 2'd3);
  assign push    = accept && !req_err && op_wr && (reg_sel == 2'd0);
  assign ctrl_wr = accept && !req_err && op_wr && (reg_sel == 2'd2);
  assign flush   = ctrl_wr && tl_i.a_data[1];

  assign empty    = (level_q == '0);
  assign full     = (level_q == LW'(DEPTH));
  assign valid_o  = en_q && !empty;
  assign sample_o = empty ? '0 : mem_q[rptr_q];
  assign pop      = valid_o && ready_i;
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push_ok  = push && (!full || pop);

  logic unused_bits;
  assign unused_bits = ^{tl_i.a_param, tl_i.a_mask, tl_i.a_address, tl_i.a_data};

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: rdata = 32'(sample_o);
      2'd1: begin
        rdata[6:0] = 7'(level_q);
        rdata[8]   = empty;
        rdata[9]   = full;
        rdata[16]  = ovf_q;
      end
      2'd2:    rdata[0] = en_q;
      default: rdata = '0;
    endcase
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    en_d    = en_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + PW'(1);
      if (pop)     rptr_d = rptr_q + PW'(1);
      level_d = level_q + LW'(push_ok) - LW'(pop);
    end
    if (push && full && !pop)              ovf_d = 1'b1;
    else if (ctrl_wr && tl_i.a_data[2])    ovf_d = 1'b0;
    if (ctrl_wr) en_d = tl_i.a_data[0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rst_q      <= 1'b0;
      mem_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      en_q       <= 1'b0;
      ovf_q      <= 1'b0;
      d_valid_q  <= 1'b0;
      d_error_q  <= 1'b0;
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
    end else begin
      rst_q   <= 1'b1;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
      if (push_ok) mem_q[wptr_q] <= tl_i.a_data[DW-1:0];
      // Response fields are captured at acceptance and held until d_ready.
      if (accept) begin
        d_valid_q  <= 1'b1;
        d_opcode_q <= op_rd ? AccessAckData : AccessAck;
        d_size_q   <= tl_i.a_size;
        d_source_q <= tl_i.a_source;
        d_error_q  <= req_err;
        d_data_q   <= (op_rd && !req_err) ? rdata : '0;
      end else if (tl_i.d_ready) begin
        d_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = d_valid_q;
    tl_o.d_opcode = d_opcode_q;
    tl_o.d_size   = d_size_q;
    tl_o.d_source = d_source_q;
    tl_o.d_data   = d_data_q;
    tl_o.d_error  = d_error_q;
    tl_o.a_ready  = a_ready;
  end

endmodule

// File: tb/tb_student_fir_sample_fifo.sv
// Randomized scoreboard bench for student_fir_sample_fifo against a queue-based model.
module tb_student_fir_sample_fifo;
  import tlul_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_ni;
  tl_h2d_t       tl_i;
  tl_d2h_t       tl_o;
  logic [DW-1:0] sample_o;
  logic          valid_o;
  logic          ready_i;

  always #5 clk = ~clk;

  student_fir_sample_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .tl_i(tl_i), .tl_o(tl_o),
    .sample_o(sample_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  src;
    logic [1:0]  sz;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  int          n_vec = 0;
  int          n_bad = 0;
  rsp_t        exp_q[$];
  int unsigned mdl_q[$];
  bit          mdl_en, mdl_ovf;
  int          rdy_mode;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Consumer ready pattern: 0 = left to directed code, 1 = toggle, 2 = random.
  initial begin
    ready_i = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1)      ready_i = !ready_i;
      else if (rdy_mode == 2) ready_i = 1'($urandom_range(0, 1));
    end
  end

  // Reference model: sees exactly what the next rising edge will act on.
  bit          m_pop, m_ev;
  logic [1:0]  m_sel;
  logic [2:0]  m_op;
  rsp_t        m_r;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        mdl_q.delete();
        exp_q.delete();
        mdl_en  = 0;
        mdl_ovf = 0;
      end else begin
        m_ev = mdl_en && (mdl_q.size() > 0);
        chk("valid_o", 32'(valid_o), 32'(m_ev));
        m_pop = m_ev && ready_i;
        if (m_pop) chk("sample_o", 32'(sample_o), mdl_q[0]);
        if (tl_i.a_valid && tl_o.a_ready) begin
          m_sel    = tl_i.a_address[3:2];
          m_op     = tl_i.a_opcode;
          m_r.op   = (m_op == 3'd4) ? 3'd1 : 3'd0;
          m_r.src  = tl_i.a_source;
          m_r.sz   = tl_i.a_size;
          m_r.err  = !(m_op == 3'd0 || m_op == 3'd1 || m_op == 3'd4) || (m_sel == 2'd3);
          m_r.data = 0;
          if (!m_r.err && m_op == 3'd4) begin
            case (m_sel)
              2'd0: m_r.data = (mdl_q.size() > 0) ? mdl_q[0] : 0;
              2'd1: m_r.data = mdl_q.size() + ((mdl_q.size() == 0) ? 32'h100 : 0)
                             + ((mdl_q.size() == DEPTH) ? 32'h200 : 0)
                             + (mdl_ovf ? 32'h10000 : 0);
              default: m_r.data = {31'd0, mdl_en};
            endcase
          end
          exp_q.push_back(m_r);
          if (m_pop) void'(mdl_q.pop_front());
          if (!m_r.err && m_op != 3'd4) begin
            if (m_sel == 2'd0) begin
              if (mdl_q.size() < DEPTH) mdl_q.push_back(tl_i.a_data & 32'hFFFF);
              else mdl_ovf = 1;
            end else if (m_sel == 2'd2) begin
              mdl_en = tl_i.a_data[0];
              if (tl_i.a_data[1]) mdl_q.delete();
              if (tl_i.a_data[2]) mdl_ovf = 0;
            end
          end
        end else if (m_pop) begin
          void'(mdl_q.pop_front());
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a d-channel handshake is due.
  rsp_t s_r;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_ni && tl_o.d_valid && tl_i.d_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected response: got d_valid=1, expected none");
        end else begin
          s_r = exp_q.pop_front();
          chk("d_opcode", 32'(tl_o.d_opcode), 32'(s_r.op));
          chk("d_source", 32'(tl_o.d_source), 32'(s_r.src));
          chk("d_size",   32'(tl_o.d_size),   32'(s_r.sz));
          chk("d_data",   tl_o.d_data,        s_r.data);
          chk("d_error",  32'(tl_o.d_error),  32'(s_r.err));
        end
      end
    end
  end

  task automatic tl_req(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] data,
                        input int hold, output logic [31:0] rdata, output logic err);
    bit          got;
    logic [31:0] d0;
    rdata = '0;
    err   = 1'b0;
    d0    = '0;
    @(posedge clk); #1;
    tl_i.a_valid   = 1'b1;
    tl_i.a_opcode  = op;
    tl_i.a_address = addr;
    tl_i.a_data    = data;
    tl_i.a_source  = 8'($urandom);
    tl_i.a_size    = 2'd2;
    tl_i.a_mask    = 4'($urandom);
    if (hold > 0) tl_i.d_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = tl_o.a_ready;
    end
    if (!got) chk("a_ready timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    tl_i.a_valid = 1'b0;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("hold d_valid", 32'(tl_o.d_valid), 32'd1);
        chk("hold a_ready", 32'(tl_o.a_ready), 32'd0);
        if (i == 0) d0 = tl_o.d_data;
        else        chk("hold d_data", tl_o.d_data, d0);
      end
      @(posedge clk); #1;
      tl_i.d_ready = 1'b1;
    end
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (tl_o.d_valid && tl_i.d_ready) begin
        got   = 1;
        rdata = tl_o.d_data;
        err   = tl_o.d_error;
      end
    end
    if (!got) chk("d_valid timeout", 32'(got), 32'd1);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] v);
    logic e;
    tl_req(addr, Get, 32'd0, 0, v, e);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] v, output logic e);
    logic [31:0] d;
    tl_req(addr, PutFullData, v, 0, d, e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [31:0] v, a;
  logic        e;
  initial begin
    tl_i         = '0;
    tl_i.d_ready = 1'b1;
    rst_ni       = 1'b0;
    rdy_mode     = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst a_ready",  32'(tl_o.a_ready), 32'd0);
    chk("rst d_valid",  32'(tl_o.d_valid), 32'd0);
    chk("rst d_data",   tl_o.d_data,       32'd0);
    chk("rst valid_o",  32'(valid_o),      32'd0);
    chk("rst sample_o", 32'(sample_o),     32'd0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    chk("a_ready after reset", 32'(tl_o.a_ready), 32'd1);

    rd(32'h4, v);  chk("status after reset", v, 32'h100);

    ready_i = 1'b1;
    wr(32'h0, 32'h1111, e);
    wr(32'h0, 32'h2222, e);
    wr(32'h0, 32'h3333, e);
    rd(32'h4, v);  chk("status level 3", v, 32'h3);
    rd(32'h0, v);  chk("data peek", v, 32'h1111);
    chk("valid_o while disabled", 32'(valid_o), 32'd0);

    wr(32'h8, 32'h1, e);
    repeat (6) @(negedge clk);
    rd(32'h4, v);  chk("status after stream", v, 32'h100);

    wr(32'h8, 32'h0, e);
    for (int i = 1; i <= 9; i++) begin
      wr(32'h0, 32'(i), e);
      chk("push d_error", 32'(e), 32'd0);
    end
    rd(32'h4, v);  chk("status overflow full", v, 32'h10208);
    wr(32'h8, 32'h1, e);
    repeat (12) @(negedge clk);
    wr(32'h8, 32'h4, e);
    rd(32'h4, v);  chk("status ovf cleared", v, 32'h100);

    wr(32'h8, 32'h1, e);
    rdy_mode = 1;
    for (int i = 0; i < 20; i++) wr(32'h0, $urandom, e);
    rdy_mode = 0;
    ready_i  = 1'b1;
    repeat (20) @(negedge clk);
    rd(32'h4, v);  chk("status after wrap", v, 32'h100);

    wr(32'h8, 32'h0, e);
    wr(32'h0, 32'hABCD, e);
    wr(32'h0, 32'h1234, e);
    tl_req(32'hC, Get, 32'd0, 0, v, e);          chk("0xC d_error", 32'(e), 32'd1);
    tl_req(32'h0, 3'd2, 32'h5555, 0, v, e);      chk("bad opcode d_error", 32'(e), 32'd1);
    tl_req(32'h4, Get, 32'd0, 5, v, e);          chk("status after errors", v, 32'h2);
    rd(32'h0, v);  chk("head after errors", v, 32'hABCD);

    rdy_mode = 2;
    for (int n = 0; n < 300; n++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin a[3:2] = 2'd0; wr(a, $urandom, e); end
        5:             begin a[3:2] = 2'($urandom_range(0, 3)); rd(a, v); end
        6:             begin a[3:2] = 2'd2; wr(a, ($urandom_range(0, 3) == 0) ? 32'h3 : 32'($urandom_range(0, 7)) | 32'h1, e); end
        7:             tl_req(a, 3'($urandom_range(0, 7)), $urandom, 0, v, e);
        8:             begin a[3:2] = 2'd1; wr(a, $urandom, e); end
        default:       begin a[3:2] = 2'd0; tl_req(a, PutPartialData, $urandom, 0, v, e); end
      endcase
    end
    rdy_mode = 0;
    ready_i  = 1'b1;
    wr(32'h8, 32'h1, e);
    repeat (20) @(negedge clk);
    rd(32'h4, v);  chk("final status level", v & 32'h37F, 32'h100);
    repeat (3) @(negedge clk);
    chk("pending responses", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/student_fir_sample_fifo.md
# student_fir_sample_fifo

TL-UL device that buffers input samples for the FIR filter datapath. It is one device port behind `student_tlul_mux` and occupies one 16-byte window. Software pushes samples through a DATA register. The block streams them out to the filter core over a valid/ready interface, and exposes fill level and overflow status.

## Interface
- `DW`, 16: sample width in bits (1..32); `a_data[DW-1:0]` is used.
- `DEPTH`, 8: FIFO entries; must be a power of two, 2..64.
- `clk_i`  in  1  single clock, rising edge.
- `rst_ni`  in  1  reset, synchronous and active-low.
- `tl_i`  in  `tlul_pkg::tl_h2d_t`  TL-UL request channel from the mux.
- `tl_o`  out  `tlul_pkg::tl_d2h_t`  TL-UL response channel to the mux.
- `sample_o`  out  DW  head-of-FIFO sample.
- `valid_o`  out  1  `sample_o` is valid.
- `ready_i`  in  1  consumer accepts the sample.

## Operation
- Register map decodes `a_address[3:2]` only; all other address bits are ignored.
  - 0x0 DATA: a write pushes `a_data[DW-1:0]`. A read returns the head sample, zero-extended, without popping; it returns 0 when empty.
  - 0x4 STATUS (read-only): `[6:0]` level, `[8]` empty, `[9]` full, `[16]` overflow (sticky). Writes are acked and ignored.
  - 0x8 CTRL: `[0]` stream enable (read/write). `[1]` flush: write-1, self-clearing, reads as 0. `[2]` clear overflow: write-1, reads as 0.
  - 0xC: any access returns `d_error=1` with no side effect.
- Opcodes: Get (4) gives AccessAckData (1). PutFullData (0) and PutPartialData (1) give AccessAck (0); `a_mask` is ignored. Any other opcode gives `d_error=1` with no side effect.
- The response echoes `a_source` and `a_size`. `d_data` is 0 for write responses.
- Push when full (and no pop in the same cycle):
  - data is dropped;
  - overflow is set;
  - the response has `d_error=0`.
- Pop: occurs when `valid_o && ready_i`. `valid_o = enable && !empty`. `sample_o` is the entry at the read pointer and is 0 when empty.
- Push and pop in the same cycle:
  - When full, the push is accepted and the level is unchanged.
  - When empty, the push is accepted and no pop occurs, because `valid_o` is 0.
- Flush in the same cycle as a pop: flush wins. Pointers and level go to 0 and overflow is unchanged.
- A flush write is a single access and cannot coincide with a push.
- Clearing overflow in the same cycle as an overflowing push is impossible, because only one TL access is accepted per cycle.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Level is `$clog2(DEPTH)+1` bits, with range 0..DEPTH.

## Timing
- Reset values while `rst_ni` is low:
  - `a_ready=0`;
  - `d_valid=0` and all d-channel fields 0;
  - `valid_o=0` and `sample_o=0`;
  - enable=0, overflow=0, level=0, pointers=0.
- Reset mid-transaction discards the pending response and all FIFO content.
- One outstanding request at a time. `a_ready = rst_q && !d_valid`, where `rst_q` is `rst_ni` registered.
- A request is accepted on the edge where `a_valid && a_ready`. All side effects (push, CTRL update) commit on that edge.
- Read data is sampled from the state before that edge.
- `d_valid` rises the cycle after acceptance, so latency is 1 cycle. It is held with stable fields until `d_ready`, then drops.
- The next request can be accepted the cycle after `d_valid && d_ready`.
- A pushed sample is visible on `valid_o` and `sample_o` the cycle after acceptance, if enable=1.
- The stream can pop every cycle; sustained pop throughput is 1 sample/cycle.
- Setting enable takes effect on `valid_o` the cycle after the CTRL write is accepted. Clearing enable also takes effect one cycle later; an in-flight handshake on the write edge still pops.

## Test plan
- Reset then STATUS read: returns 0x100 (empty=1, level=0). `valid_o=0`. `a_ready=0` during reset and 1 after.
- Push 0x1111, 0x2222, 0x3333 with enable=0:
  - STATUS returns level 3;
  - a DATA read returns 0x1111;
  - `valid_o` stays 0.
- Continuing that state, write CTRL=1 with `ready_i=1`:
  - `sample_o` gives 0x1111, 0x2222, 0x3333 on consecutive cycles;
  - then `valid_o=0` and STATUS returns 0x100.
- With DEPTH=8 and enable=0, push 9 values 1..9:
  - STATUS returns 0x10208 (overflow, full, level 8);
  - all responses have `d_error=0`;
  - draining yields 1..8;
  - CTRL=4 then clears overflow.
- With enable=1 and `ready_i` toggling every cycle while pushes arrive back-to-back: the output order is preserved with no loss, and pointers wrap past entry 7.
- Error cases, each of which must leave the state unchanged:
  - a Get to 0xC returns `d_error=1`;
  - opcode 2 to 0x0 returns `d_error=1` with no push;
  - holding `d_ready=0` for 5 cycles keeps `d_valid` and `d_data` stable and `a_ready=0`.
